// File: rtl/nn_fixed_pkg.sv
`default_nettype none
// =============================================================================
// Package : nn_fixed_pkg
// Brief   : Q8.8 fixed-point constants, FSM encoding and saturation helpers.
// Revision: 1.0
// =============================================================================
package nn_fixed_pkg;

  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 18;

  localparam logic [W-1:0] Q_ONE = 16'h0100;
  localparam logic [W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [W-1:0] q_sat18to16(input logic signed [ACC_W-1:0] x);
    if (x > 18'sh07FFF)
      return Q_MAX;
    else if (x < -18'sh08000)
      return Q_MIN;
    else
      return x[W-1:0];
  endfunction

  // Accumulate without wrapping: widen by one bit, then clamp back to 18 bits.
  function automatic logic signed [ACC_W-1:0] q_add_sat18(input logic signed [ACC_W-1:0] a,
                                                          input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
    if (s > 19'sh1FFFF)
      return 18'sh1FFFF;
    else if (s < -19'sh20000)
      return 18'sh20000;
    else
      return s[ACC_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_mul.sv
`default_nettype none
// =============================================================================
// Module  : q_mul
// Brief   : Signed Q8.8 multiply, floor-rescaled by FRAC, clamped to 18 bits.
// Revision: 1.0
// =============================================================================
module q_mul
  import nn_fixed_pkg::*;
#(
  parameter int QW    = W,
  parameter int QFRAC = FRAC
) (
  input  logic signed [QW-1:0]    a_i,
  input  logic signed [QW-1:0]    b_i,
  output logic signed [ACC_W-1:0] p_o
);

  localparam logic signed [2*QW-1:0] c_HI = (2*QW)'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
  localparam logic signed [2*QW-1:0] c_LO = -c_HI - 1;

  logic signed [2*QW-1:0] w_prod;
  logic signed [2*QW-1:0] w_shift;

  assign w_prod  = a_i * b_i;
  assign w_shift = w_prod >>> QFRAC;

  always_comb begin
    p_o = w_shift[ACC_W-1:0];
    if (w_shift > c_HI)
      p_o = c_HI[ACC_W-1:0];
    else if (w_shift < c_LO)
      p_o = c_LO[ACC_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/neural_layer_backprop.sv
`default_nettype none
// =============================================================================
// Module  : neural_layer_backprop
// Brief   : 2x2 layer backward pass (errors + SGD weight update), one shared
//           multiplier over 8 steps, valid/ready on input and output.
// Revision: 1.0
// =============================================================================
module neural_layer_backprop
  import nn_fixed_pkg::*;
#(
  parameter int LR_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  input  logic [W-1:0] caa_i,
  input  logic [W-1:0] cab_i,
  input  logic [W-1:0] cba_i,
  input  logic [W-1:0] cbb_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] ea_o,
  output logic [W-1:0] eb_o,
  output logic [W-1:0] naa_o,
  output logic [W-1:0] nab_o,
  output logic [W-1:0] nba_o,
  output logic [W-1:0] nbb_o
);

  state_e state_q, state_d;
  logic [2:0] step_q, step_d;

  logic [W-1:0] a_q, b_q, d1_q, d2_q, caa_q, cab_q, cba_q, cbb_q;
  logic [W-1:0] ea_q, eb_q, naa_q, nab_q, nba_q, nbb_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [W-1:0]     w_x, w_y;
  logic [W-1:0]            w_c;
  logic signed [ACC_W-1:0] w_p, w_g, w_sum, w_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Handshake outputs depend only on the registered state.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d = ST_CALC;
          step_d  = 3'd0;
        end
      end
      ST_CALC: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd7)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Steps 0-3 form the errors, steps 4-7 the weight gradients AA, AB, BA, BB.
  always_comb begin
    w_x = $signed(d1_q);
    w_y = $signed(caa_q);
    w_c = caa_q;
    unique case (step_q)
      3'd0: begin w_x = $signed(d1_q); w_y = $signed(caa_q); end
      3'd1: begin w_x = $signed(d2_q); w_y = $signed(cab_q); end
      3'd2: begin w_x = $signed(d1_q); w_y = $signed(cba_q); end
      3'd3: begin w_x = $signed(d2_q); w_y = $signed(cbb_q); end
      3'd4: begin w_x = $signed(a_q);  w_y = $signed(d1_q); w_c = caa_q; end
      3'd5: begin w_x = $signed(a_q);  w_y = $signed(d2_q); w_c = cab_q; end
      3'd6: begin w_x = $signed(b_q);  w_y = $signed(d1_q); w_c = cba_q; end
      3'd7: begin w_x = $signed(b_q);  w_y = $signed(d2_q); w_c = cbb_q; end
      default: ;
    endcase
  end

  q_mul u_mul (
    .a_i (w_x),
    .b_i (w_y),
    .p_o (w_p)
  );

  assign w_g   = w_p >>> LR_SHIFT;
  assign w_sum = q_add_sat18(acc_q, w_p);
  assign w_sub = $signed({{(ACC_W-W){w_c[W-1]}}, w_c}) - w_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      {a_q, b_q, d1_q, d2_q}         <= '0;
      {caa_q, cab_q, cba_q, cbb_q}   <= '0;
      {ea_q, eb_q}                   <= '0;
      {naa_q, nab_q, nba_q, nbb_q}   <= '0;
      acc_q                          <= '0;
    end else if (state_q == ST_IDLE && in_valid_i) begin
      a_q   <= a_i;   b_q   <= b_i;
      d1_q  <= d1_i;  d2_q  <= d2_i;
      caa_q <= caa_i; cab_q <= cab_i;
      cba_q <= cba_i; cbb_q <= cbb_i;
    end else if (state_q == ST_CALC) begin
      unique case (step_q)
        3'd0, 3'd2: acc_q <= w_p;
        3'd1: ea_q  <= q_sat18to16(w_sum);
        3'd3: eb_q  <= q_sat18to16(w_sum);
        3'd4: naa_q <= q_sat18to16(w_sub);
        3'd5: nab_q <= q_sat18to16(w_sub);
        3'd6: nba_q <= q_sat18to16(w_sub);
        3'd7: nbb_q <= q_sat18to16(w_sub);
        default: ;
      endcase
    end
  end

  assign ea_o  = ea_q;
  assign eb_o  = eb_q;
  assign naa_o = naa_q;
  assign nab_o = nab_q;
  assign nba_o = nba_q;
  assign nbb_o = nbb_q;

endmodule
`default_nettype wire

// File: tb/tb_neural_layer_backprop.sv
`default_nettype none
// =============================================================================
// Module  : tb_neural_layer_backprop
// Brief   : Directed self-checking bench for neural_layer_backprop.
// Revision: 1.0
// =============================================================================
module tb_neural_layer_backprop;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0, d1 = '0, d2 = '0;
  logic [15:0] caa = '0, cab = '0, cba = '0, cbb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] ea, eb, naa, nab, nba, nbb;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  neural_layer_backprop #(.LR_SHIFT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .d1_i        (d1),
    .d2_i        (d2),
    .caa_i       (caa),
    .cab_i       (cab),
    .cba_i       (cba),
    .cbb_i       (cbb),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ea_o        (ea),
    .eb_o        (eb),
    .naa_o       (naa),
    .nab_o       (nab),
    .nba_o       (nba),
    .nbb_o       (nbb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] va, vb, vd1, vd2, vaa, vab, vba, vbb);
    a = va; b = vb; d1 = vd1; d2 = vd2;
    caa = vaa; cab = vab; cba = vba; cbb = vbb;
  endtask

  // Present a bundle and return just after the edge that accepts it.
  task automatic send(input logic [15:0] va, vb, vd1, vd2, vaa, vab, vba, vbb);
    int n;
    drive(va, vb, vd1, vd2, vaa, vab, vba, vbb);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    tick();
    in_valid = 1'b0;
    drive(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3);
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] xa, xb, xaa, xab, xba, xbb);
    chk({tag, "_eA"},  ea,  xa);
    chk({tag, "_eB"},  eb,  xb);
    chk({tag, "_nAA"}, naa, xaa);
    chk({tag, "_nAB"}, nab, xab);
    chk({tag, "_nBA"}, nba, xba);
    chk({tag, "_nBB"}, nbb, xbb);
  endtask

  initial begin
    logic seen;
    logic [15:0] exp_ea  [3];
    logic [15:0] exp_eb  [3];
    logic [15:0] exp_nbb [3];

    // Reset state
    tick(); tick();
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_eA", ea, 16'h0000);
    chk("rst_nBB", nbb, 16'h0000);
    rst = 1'b0;
    tick();

    // 1: unit values
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wait_out(lat);
    chk("t1_latency", lat, 8);
    check_res("t1", 16'h0200, 16'h0200, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0);

    // 2: floor on negative products
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100);
    wait_out(lat);
    chk("t2_latency", lat, 8);
    check_res("t2", 16'hFFFE, 16'h0200, 16'hFFEF, 16'hFFEF, 16'h00F0, 16'h00F0);

    // 3: saturation on errors and weight updates
    send(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out(lat);
    chk("t3_latency", lat, 8);
    check_res("t3", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);

    // 4: backpressure in DONE, second bundle waits for in_ready
    tick();
    out_ready = 1'b0;
    send(16'h0200, 16'hFF00, 16'h0080, 16'hFF80, 16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    wait_out(lat);
    chk("t4_latency", lat, 8);
    check_res("t4", 16'hFF80, 16'hFF40, 16'h00F0, 16'h0210, 16'hFF08, 16'h0078);
    drive(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_ready", in_ready,  1'b0);
      chk("t4_hold_eA",    ea,        16'hFF80);
      chk("t4_hold_nBB",   nbb,       16'h0078);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_rel_valid", out_valid, 1'b0);
    chk("t4_rel_ready", in_ready,  1'b1);
    tick();
    chk("t4_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("t4b_latency", lat, 8);
    check_res("t4b", 16'h0200, 16'h0200, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0);

    // 5: reset during CALC step 3 drops the bundle
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF);
    tick(); tick(); tick();
    chk("t5_pre_eA", ea, 16'h0200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_in_ready",  in_ready,  1'b1);
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_eA",  ea,  16'h0000);
    chk("t5_nAA", naa, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("t5_no_stale", seen, 1'b0);

    // 6: back-to-back bundles with out_ready held high
    exp_ea[0] = 16'hFFFE; exp_eb[0] = 16'h0200; exp_nbb[0] = 16'h00F0;
    exp_ea[1] = 16'hFF80; exp_eb[1] = 16'hFF40; exp_nbb[1] = 16'h0078;
    exp_ea[2] = 16'h0200; exp_eb[2] = 16'h0200; exp_nbb[2] = 16'h00F0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100);
        1: send(16'h0200, 16'hFF00, 16'h0080, 16'hFF80, 16'h0100, 16'h0200, 16'hFF00, 16'h0080);
        default: send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      endcase
      wait_out(lat);
      chk("t6_latency", lat, 8);
      chk("t6_eA",  ea,  exp_ea[k]);
      chk("t6_eB",  eb,  exp_eb[k]);
      chk("t6_nBB", nbb, exp_nbb[k]);
    end
    tick();
    chk("t6_consumed", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
